decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Dual-entry-per-cycle circular FIFO between the 2-wide decoder and schedule_unit in the 2-issue superscalar core.
- Accepts up to two decode_s packets per cycle from the decoder.
- Compacts invalid slots and presents the oldest two entries to the scheduler, which pops them with a request/ack handshake.
- Supports a pipeline flush for redirects.

Parameters:
- DEPTH, 8, number of decode_s entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), index width. Read/write pointers carry one extra wrap bit (PTR_W+1).

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_flush  in  1  synchronous flush; empties the queue.
- i_dec_dque_valid  in  1  decoder offers a pair this cycle.
- i_dec_dque_decode_0  in  decode_s  older decoded instruction; its .valid marks slot use.
- i_dec_dque_decode_1  in  decode_s  younger decoded instruction; its .valid marks slot use.
- o_dque_dec_ready  out  1  queue can accept a full pair (free entries >= 2).
- i_sch_dque_request  in  1  scheduler pops the presented pair.
- o_dque_sch_ready  out  1  at least one entry is presented.
- o_dque_sch_ack  out  1  pop accepted this cycle.
- o_dque_sch_decode_0  out  decode_s  head entry; .valid=1 iff count >= 1.
- o_dque_sch_decode_1  out  decode_s  head+1 entry; .valid=1 iff count >= 2.

Behaviour:
- Reset:
  - Asynchronous on i_rst=1: wr_ptr=0, rd_ptr=0, count=0.
  - While i_rst=1, all outputs are 0, including o_dque_dec_ready.
  - Storage contents are don't-care but must never be presented with valid=1.
- count:
  - Width PTR_W+1, range 0..DEPTH.
  - free = DEPTH - count.
- o_dque_dec_ready = ~i_rst & (free >= 2). Combinational from registered count, so it never depends on the same-cycle pop.
- Push fires when i_dec_dque_valid & o_dque_dec_ready & ~i_flush.
  - n_push = decode_0.valid + decode_1.valid (0..2).
  - Valid slots are written in program order at wr_ptr, wr_ptr+1, compacted.
  - If only decode_1 is valid, it goes to wr_ptr.
  - n_push=0 is legal and changes nothing.
- Head presentation:
  - decode_0 = mem[rd_ptr]; decode_1 = mem[rd_ptr+1] (mod DEPTH).
  - Each .valid is overridden per count; the remaining fields are passed unchanged.
  - o_dque_sch_ready = (count >= 1).
- Pop fires when i_sch_dque_request & o_dque_sch_ready & ~i_flush.
  - o_dque_sch_ack = pop (combinational, same cycle).
  - n_pop = min(count, 2); rd_ptr advances by n_pop.
  - A request while empty gives ack=0 and no state change.
- Simultaneous push and pop: count_next = count + n_push - n_pop; pointers wrap mod DEPTH.
  - A full queue with a simultaneous pop still refuses the push, because ready was already low.
- Latency (no optional feature): an entry pushed in cycle N is presented in cycle N+1 at the earliest. No combinational input-to-output path except request->ack.
- Flush:
  - Next edge: rd_ptr=wr_ptr=0, count=0.
  - Overrides push and pop in the same cycle: ack=0, nothing written.
  - Outputs show valid=0 from the following cycle.
- Reset mid-operation discards all contents immediately; no partial state survives.
- Ordering: strict FIFO; entries are never reordered or duplicated.

Optional Feature:
- DQUE_BYPASS_EN defined, when count==0 and a push fires:
  - The compacted incoming pair drives o_dque_sch_decode_0/1 and o_dque_sch_ready in the same cycle.
  - If the pop also fires, the presented entries are consumed and not written, and count stays 0.
  - If there is no pop, entries are written normally.
  - Zero-cycle latency when empty.
- DQUE_BYPASS_EN undefined: pure registered behaviour, 1-cycle minimum latency, as described above.

Test Plan:
- Reset then idle: i_rst high 5 cycles, release.
  - During reset: all outputs 0.
  - First cycle after: o_dque_dec_ready=1, o_dque_sch_ready=0.
- Push pair A0,A1 (both valid), no request:
  - Next cycle: decode_0=A0, decode_1=A1, both valid.
  - Request that cycle: ack=1, queue empty after.
- Push with only decode_1 valid (B1), then pair C0,C1:
  - Presented B1, C0.
  - After pop: C1 alone with decode_1.valid=0; second pop empties, count=0.
- Fill with DEPTH=8 via 4 full pushes:
  - o_dque_dec_ready=0 at count=8; a push attempt is ignored.
  - One pop gives count=6, ready=1.
  - Push+pop same cycle gives count unchanged; wrap-around order preserved over 20 pairs vs reference model.
- Flush with count=5 while request and push are asserted:
  - ack=0, no write.
  - Next cycle: count=0, both outputs valid=0.
- Assert i_rst for 1 cycle with count=3 mid-stream: outputs drop to 0 asynchronously and the queue is empty after release.
- DQUE_BYPASS_EN only: empty queue, push D0,D1 with request high → same-cycle ack=1, outputs D0,D1, count remains 0.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: 2-in/2-out circular FIFO between the decoder and the scheduler.
// Optional same-cycle bypass when empty is enabled by defining DQUE_BYPASS_EN.

package decode_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
  } decode_s;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_flush,
  input  logic    i_dec_dque_valid,
  input  decode_s i_dec_dque_decode_0,
  input  decode_s i_dec_dque_decode_1,
  output logic    o_dque_dec_ready,
  input  logic    i_sch_dque_request,
  output logic    o_dque_sch_ready,
  output logic    o_dque_sch_ack,
  output decode_s o_dque_sch_decode_0,
  output decode_s o_dque_sch_decode_1
);

  localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W + 1)'(DEPTH - 2);
  localparam logic [PTR_W:0] ONE_C      = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] TWO_C      = (PTR_W + 1)'(2);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_s;
  logic [PTR_W-1:0] wr_idx0_s, wr_idx1_s, rd_idx0_s, rd_idx1_s;
  decode_s          mem_q [DEPTH];

  logic       dec_ready_s, sch_ready_s;
  logic       push_s, pop_s, bypass_s, write_en_s;
  logic [1:0] n_push_s, n_pop_s, push_amt_s, pop_amt_s;
  decode_s    wr_0_s, wr_1_s, head_0_s, head_1_s;

  // The wrap bit makes the pointer difference span 0..DEPTH.
  assign count_s   = wr_ptr_q - rd_ptr_q;
  assign wr_idx0_s = wr_ptr_q[PTR_W-1:0];
  assign wr_idx1_s = wr_idx0_s + {{(PTR_W-1){1'b0}}, 1'b1};
  assign rd_idx0_s = rd_ptr_q[PTR_W-1:0];
  assign rd_idx1_s = rd_idx0_s + {{(PTR_W-1){1'b0}}, 1'b1};

  assign dec_ready_s = ~i_rst & (count_s <= PUSH_LIMIT);
  assign push_s      = i_dec_dque_valid & dec_ready_s & ~i_flush;
  assign n_push_s    = {1'b0, i_dec_dque_decode_0.valid} + {1'b0, i_dec_dque_decode_1.valid};

`ifdef DQUE_BYPASS_EN
  assign bypass_s = push_s & (count_s == '0);
`else
  assign bypass_s = 1'b0;
`endif

  // Compact the incoming pair so the oldest valid slot always lands at wr_ptr.
  always_comb begin
    wr_0_s = i_dec_dque_decode_1;
    wr_1_s = i_dec_dque_decode_1;
    if (i_dec_dque_decode_0.valid) begin
      wr_0_s = i_dec_dque_decode_0;
    end else begin
      wr_0_s = i_dec_dque_decode_1;
    end
  end

  // Head presentation: stored pair, or the incoming pair while bypassing.
  always_comb begin
    head_0_s    = mem_q[rd_idx0_s];
    head_1_s    = mem_q[rd_idx1_s];
    sch_ready_s = (count_s >= ONE_C);
    if (bypass_s) begin
      head_0_s       = wr_0_s;
      head_1_s       = wr_1_s;
      head_0_s.valid = (n_push_s != 2'd0);
      head_1_s.valid = (n_push_s == 2'd2);
      sch_ready_s    = (n_push_s != 2'd0);
    end else begin
      head_0_s.valid = (count_s >= ONE_C);
      head_1_s.valid = (count_s >= TWO_C);
    end
  end

  assign pop_s   = i_sch_dque_request & sch_ready_s & ~i_flush;
  assign n_pop_s = bypass_s ? n_push_s : ((count_s >= TWO_C) ? 2'd2 : count_s[1:0]);

  // Next-state pointers; a consumed bypass pair leaves the queue untouched.
  always_comb begin
    push_amt_s = 2'd0;
    pop_amt_s  = 2'd0;
    write_en_s = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (bypass_s & pop_s) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
    end else begin
      push_amt_s = push_s ? n_push_s : 2'd0;
      pop_amt_s  = pop_s ? n_pop_s : 2'd0;
      write_en_s = push_s;
      wr_ptr_d   = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_amt_s};
      rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_amt_s};
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; count gating keeps stale entries from being presented.
  always_ff @(posedge i_clk) begin
    if (write_en_s && (n_push_s != 2'd0)) begin
      mem_q[wr_idx0_s] <= wr_0_s;
    end
    if (write_en_s && (n_push_s == 2'd2)) begin
      mem_q[wr_idx1_s] <= wr_1_s;
    end
  end

  assign o_dque_dec_ready    = dec_ready_s;
  assign o_dque_sch_ready    = ~i_rst & sch_ready_s;
  assign o_dque_sch_ack      = ~i_rst & pop_s;
  assign o_dque_sch_decode_0 = i_rst ? '0 : head_0_s;
  assign o_dque_sch_decode_1 = i_rst ? '0 : head_1_s;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with a queue-based scoreboard of expected entries.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 8;

  logic    clk = 1'b0;
  logic    rst, flush, dv, req;
  decode_s d0, d1;
  logic    dec_ready, sch_ready, sch_ack;
  decode_s o_d0, o_d1;
  decode_s zero_d;
  decode_s sb[$];
  int      checks   = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_flush             (flush),
    .i_dec_dque_valid    (dv),
    .i_dec_dque_decode_0 (d0),
    .i_dec_dque_decode_1 (d1),
    .o_dque_dec_ready    (dec_ready),
    .i_sch_dque_request  (req),
    .o_dque_sch_ready    (sch_ready),
    .o_dque_sch_ack      (sch_ack),
    .o_dque_sch_decode_0 (o_d0),
    .o_dque_sch_decode_1 (o_d1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic decode_s mk(input logic v);
    decode_s r;
    r.valid = v;
    r.pc    = 16'($urandom);
    r.instr = 16'($urandom);
    return r;
  endfunction

  // One clock: drive, check combinational view against the model, update model, advance.
  task automatic cycle(input string tag, input logic v, input decode_s a, input decode_s b,
                       input logic r, input logic f);
    int      n, np, k;
    logic    rdy, exp_ack, byp;
    decode_s pres[$];
    dv = v; d0 = a; d1 = b; req = r; flush = f;
    #2;
    n    = sb.size();
    rdy  = (n <= DEPTH - 2);
    byp  = 1'b0;
    pres = sb;
`ifdef DQUE_BYPASS_EN
    if (n == 0 && v && rdy && !f) begin
      byp = 1'b1;
      if (a.valid) pres.push_back(a);
      if (b.valid) pres.push_back(b);
    end
`endif
    np      = pres.size();
    exp_ack = r & ~f & (np >= 1);
    chk({tag, ":dec_ready"}, 64'(dec_ready), 64'(rdy));
    chk({tag, ":sch_ready"}, 64'(sch_ready), 64'(np >= 1));
    chk({tag, ":ack"}, 64'(sch_ack), 64'(exp_ack));
    chk({tag, ":v0"}, 64'(o_d0.valid), 64'(np >= 1));
    chk({tag, ":v1"}, 64'(o_d1.valid), 64'(np >= 2));
    if (np >= 1) chk({tag, ":d0"}, 64'(o_d0), 64'(pres[0]));
    if (np >= 2) chk({tag, ":d1"}, 64'(o_d1), 64'(pres[1]));
    if (f) begin
      sb.delete();
    end else if (byp && exp_ack) begin
      k = 0;
    end else begin
      if (exp_ack) begin
        k = (n >= 2) ? 2 : n;
        repeat (k) void'(sb.pop_front());
      end
      if (v && rdy) begin
        if (a.valid) sb.push_back(a);
        if (b.valid) sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, zero_d, zero_d, 1'b0, 1'b0);
  endtask

  initial begin
    zero_d = '0;
    rst = 1'b1; flush = 1'b0; dv = 1'b0; req = 1'b1; d0 = '0; d1 = '0;

    // Reset held for five cycles with outputs forced low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst:dec_ready", 64'(dec_ready), 64'd0);
    chk("rst:sch_ready", 64'(sch_ready), 64'd0);
    chk("rst:ack", 64'(sch_ack), 64'd0);
    chk("rst:d0", 64'(o_d0), 64'd0);
    chk("rst:d1", 64'(o_d1), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    idle("post_rst");

    // Pair A, popped the following cycle.
    cycle("pushA", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("popA", 1'b0, zero_d, zero_d, 1'b1, 1'b0);
    idle("emptyA");

    // Lone decode_1, then pair C; pops come out B1,C0 then C1 alone.
    cycle("pushB1", 1'b1, mk(1'b0), mk(1'b1), 1'b0, 1'b0);
    cycle("pushC", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("popBC", 1'b0, zero_d, zero_d, 1'b1, 1'b0);
    cycle("popC1", 1'b0, zero_d, zero_d, 1'b1, 1'b0);
    idle("emptyC");

    // Fill to DEPTH, refused push, then push+pop on a full queue.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("full_push", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("full_pushpop", 1'b1, mk(1'b1), mk(1'b1), 1'b1, 1'b0);
    idle("count6");

    // Streaming push+pop with mixed slot validity across pointer wrap.
    for (int i = 0; i < 20; i++)
      cycle("stream", 1'b1, mk(1'($urandom_range(0, 1))), mk(1'($urandom_range(0, 1))), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle("drain", 1'b0, zero_d, zero_d, 1'b1, 1'b0);
    idle("drained");

    // Flush with five entries while push and request are both asserted.
    cycle("f5a", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("f5b", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("f5c", 1'b1, mk(1'b1), mk(1'b0), 1'b0, 1'b0);
    cycle("flush", 1'b1, mk(1'b1), mk(1'b1), 1'b1, 1'b1);
    idle("post_flush");
    cycle("flush_push", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("flush_pop", 1'b0, zero_d, zero_d, 1'b1, 1'b0);

    // Asynchronous reset with three entries in flight.
    cycle("r3a", 1'b1, mk(1'b1), mk(1'b1), 1'b0, 1'b0);
    cycle("r3b", 1'b1, mk(1'b0), mk(1'b1), 1'b0, 1'b0);
    dv = 1'b0; req = 1'b0; d0 = '0; d1 = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst:sch_ready", 64'(sch_ready), 64'd0);
    chk("mid_rst:dec_ready", 64'(dec_ready), 64'd0);
    chk("mid_rst:d0", 64'(o_d0), 64'd0);
    chk("mid_rst:d1", 64'(o_d1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    idle("after_mid_rst");
    cycle("after_rst_pop", 1'b0, zero_d, zero_d, 1'b1, 1'b0);

`ifdef DQUE_BYPASS_EN
    // Empty queue: pair consumed in the same cycle, nothing stored.
    cycle("bypass", 1'b1, mk(1'b1), mk(1'b1), 1'b1, 1'b0);
    idle("bypass_empty");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
